// File: rtl/dmem_port_arbiter.sv
// Two-master data-memory port arbiter: round-robin singles, locked m0 bursts.
// Optional ARB_PERF_CNT_EN adds the m1 wait-cycle counter output m1_wait_cnt.
module dmem_port_arbiter #(
    parameter int VEC_LEN = 4,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             m0_req,
    input  logic             m0_we,
    input  logic             m0_burst,
    input  logic [31:0]      m0_addr,
    input  logic [31:0]      m0_wdata,
    output logic             m0_gnt,
    output logic             m0_rvalid,
    output logic             m0_rlast,
    output logic [31:0]      m0_rdata,
    input  logic             m1_req,
    input  logic             m1_we,
    input  logic [31:0]      m1_addr,
    input  logic [31:0]      m1_wdata,
    output logic             m1_gnt,
    output logic             m1_rvalid,
    output logic [31:0]      m1_rdata,
    output logic             mem_en,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic [31:0]      mem_rdata,
`ifdef ARB_PERF_CNT_EN
    output logic [CNT_W-1:0] m1_wait_cnt,
`endif
    output logic             busy
);

    localparam int BW = (VEC_LEN > 2) ? $clog2(VEC_LEN) : 1;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t        state;
    logic          rr;
    logic [31:0]   base;
    logic [BW-1:0] beat;
    logic [31:0]   burst_addr;
    logic [31:0]   raw_addr;
    logic          last_beat;
    logic          burst_fin;

    assign last_beat  = (beat == BW'(VEC_LEN - 1));
    assign burst_addr = base + (32'(beat) << 2);
    assign burst_fin  = (state == BURST) && m0_gnt && last_beat;
    assign busy       = (state == BURST);

    // Grants are combinational so the beat issues in the request cycle.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (!reset) begin
            if (state == BURST) begin
                m0_gnt = m0_req;
            end else begin
                m0_gnt = m0_req && (!m1_req || !rr);
                m1_gnt = m1_req && !m0_gnt;
            end
        end
    end

    always_comb begin
        mem_en    = m0_gnt || m1_gnt;
        mem_we    = 1'b0;
        raw_addr  = 32'h0;
        mem_wdata = 32'h0;
        if (m0_gnt) begin
            mem_we    = m0_we;
            raw_addr  = (state == BURST) ? burst_addr : m0_addr;
            mem_wdata = m0_wdata;
        end else if (m1_gnt) begin
            mem_we    = m1_we;
            raw_addr  = m1_addr;
            mem_wdata = m1_wdata;
        end
        mem_addr = {raw_addr[31:2], 2'b00};
    end

    // Memory read data lands the cycle after issue; gate it by the flag.
    assign m0_rdata = m0_rvalid ? mem_rdata : 32'h0;
    assign m1_rdata = m1_rvalid ? mem_rdata : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr        <= 1'b0;
            base      <= 32'h0;
            beat      <= '0;
            m0_rvalid <= 1'b0;
            m0_rlast  <= 1'b0;
            m1_rvalid <= 1'b0;
        end else begin
            m0_rvalid <= m0_gnt && !m0_we;
            m0_rlast  <= burst_fin && !m0_we;
            m1_rvalid <= m1_gnt && !m1_we;
            unique case (state)
                IDLE: begin
                    if (m0_gnt) begin
                        rr <= 1'b1;
                        if (m0_burst) begin
                            base  <= m0_addr;
                            beat  <= BW'(1);
                            state <= BURST;
                        end
                    end else if (m1_gnt) begin
                        rr <= 1'b0;
                    end
                end
                BURST: begin
                    if (m0_gnt) begin
                        if (last_beat) begin
                            state <= IDLE;
                            beat  <= '0;
                            rr    <= 1'b1;
                        end else begin
                            beat <= beat + BW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            m1_wait_cnt <= '0;
        end else if (m1_req && !m1_gnt && !(&m1_wait_cnt)) begin
            m1_wait_cnt <= m1_wait_cnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed self-checking bench for dmem_port_arbiter.
module tb_dmem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m0_we, m0_burst;
    logic [31:0] m0_addr, m0_wdata;
    logic        m0_gnt, m0_rvalid, m0_rlast;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_we;
    logic [31:0] m1_addr, m1_wdata;
    logic        m1_gnt, m1_rvalid;
    logic [31:0] m1_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        busy;
`ifdef ARB_PERF_CNT_EN
    logic [15:0] m1_wait_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    dmem_port_arbiter #(.VEC_LEN(4), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_burst(m0_burst),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rlast(m0_rlast),
        .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
`ifdef ARB_PERF_CNT_EN
        .m1_wait_cnt(m1_wait_cnt),
`endif
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_req = 0; m0_we = 0; m0_burst = 0;
        m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        cyc();
        cyc();
        reset = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1;
        m0_req = 1; m1_req = 1;
        mem_rdata = 32'h1234_5678;
        #2;
        if (m0_gnt !== 1'b0) begin $display("FAIL rst_m0_gnt got %h want 0", m0_gnt); n_bad++; end
        n_cmp++;
        if (m1_gnt !== 1'b0) begin $display("FAIL rst_m1_gnt got %h want 0", m1_gnt); n_bad++; end
        n_cmp++;
        if (mem_en !== 1'b0) begin $display("FAIL rst_mem_en got %h want 0", mem_en); n_bad++; end
        n_cmp++;
        cyc();
        cyc();
        #2;
        if (busy !== 1'b0) begin $display("FAIL rst_busy got %h want 0", busy); n_bad++; end
        n_cmp++;
        if (m0_rvalid !== 1'b0 || m0_rlast !== 1'b0 || m1_rvalid !== 1'b0) begin
            $display("FAIL rst_rvalid got %b%b%b want 000", m0_rvalid, m0_rlast, m1_rvalid);
            n_bad++;
        end
        n_cmp++;
        if (m0_rdata !== 32'h0) begin $display("FAIL rst_rdata got %h want 0", m0_rdata); n_bad++; end
        n_cmp++;
`ifdef ARB_PERF_CNT_EN
        if (m1_wait_cnt !== 16'd0) begin $display("FAIL rst_wait got %0d want 0", m1_wait_cnt); n_bad++; end
        n_cmp++;
`endif
        clear_inputs();
        reset = 0;
        cyc();
    endtask

    task automatic test_single_read();
        m0_req = 1; m0_addr = 32'h100;
        #2;
        if (m0_gnt !== 1'b1) begin $display("FAIL sr_gnt got %h want 1", m0_gnt); n_bad++; end
        n_cmp++;
        if (mem_en !== 1'b1 || mem_we !== 1'b0) begin
            $display("FAIL sr_en got %b%b want 10", mem_en, mem_we); n_bad++;
        end
        n_cmp++;
        if (mem_addr !== 32'h100) begin $display("FAIL sr_addr got %h want 100", mem_addr); n_bad++; end
        n_cmp++;
        cyc();
        m0_req = 0;
        mem_rdata = 32'hDEAD_BEEF;
        #2;
        if (m0_rvalid !== 1'b1 || m0_rlast !== 1'b0) begin
            $display("FAIL sr_rvalid got %b%b want 10", m0_rvalid, m0_rlast); n_bad++;
        end
        n_cmp++;
        if (m0_rdata !== 32'hDEAD_BEEF) begin $display("FAIL sr_rdata got %h want deadbeef", m0_rdata); n_bad++; end
        n_cmp++;
        if (mem_en !== 1'b0) begin $display("FAIL sr_idle got %h want 0", mem_en); n_bad++; end
        n_cmp++;
        cyc();
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int r = 0; r < 2; r++) begin
            m0_req = 1; m0_addr = 32'h104;
            m1_req = 1; m1_addr = 32'h300;
            #2;
            if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
                $display("FAIL rr%0d_first got %b%b want 10", r, m0_gnt, m1_gnt); n_bad++;
            end
            n_cmp++;
            cyc();
            m0_req = 0;
            #2;
            if (m1_gnt !== 1'b1 || mem_addr !== 32'h300) begin
                $display("FAIL rr%0d_second got %b %h want 1 300", r, m1_gnt, mem_addr); n_bad++;
            end
            n_cmp++;
            cyc();
            m1_req = 0;
            #2;
            if (m1_rvalid !== 1'b1) begin $display("FAIL rr%0d_m1_rvalid got %h want 1", r, m1_rvalid); n_bad++; end
            n_cmp++;
        end
        cyc();
    endtask

    task automatic test_burst_read();
        do_reset();
        m0_req = 1; m0_burst = 1; m0_we = 0; m0_addr = 32'h200;
        m1_req = 1; m1_addr = 32'h500;
        for (int k = 0; k < 4; k++) begin
            mem_rdata = 32'hA000_0000 + k;
            #2;
            if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
                $display("FAIL br%0d_gnt got %b%b want 10", k, m0_gnt, m1_gnt); n_bad++;
            end
            n_cmp++;
            if (mem_addr !== 32'h200 + 32'(4 * k)) begin
                $display("FAIL br%0d_addr got %h want %h", k, mem_addr, 32'h200 + 32'(4 * k)); n_bad++;
            end
            n_cmp++;
            if (k > 0) begin
                if (busy !== 1'b1) begin $display("FAIL br%0d_busy got %h want 1", k, busy); n_bad++; end
                n_cmp++;
                if (m0_rvalid !== 1'b1 || m0_rlast !== 1'b0 || m0_rdata !== 32'hA000_0000 + k) begin
                    $display("FAIL br%0d_rd got %b%b %h want 10 %h", k, m0_rvalid, m0_rlast,
                             m0_rdata, 32'hA000_0000 + k);
                    n_bad++;
                end
                n_cmp++;
            end
            cyc();
            m0_burst = 0;
        end
        m0_req = 0;
        mem_rdata = 32'hA000_0004;
        #2;
        if (m1_gnt !== 1'b1 || mem_addr !== 32'h500) begin
            $display("FAIL br_m1_gnt got %b %h want 1 500", m1_gnt, mem_addr); n_bad++;
        end
        n_cmp++;
        if (busy !== 1'b0) begin $display("FAIL br_busy_end got %h want 0", busy); n_bad++; end
        n_cmp++;
        if (m0_rvalid !== 1'b1 || m0_rlast !== 1'b1 || m0_rdata !== 32'hA000_0004) begin
            $display("FAIL br_last got %b%b %h want 11 a0000004", m0_rvalid, m0_rlast, m0_rdata);
            n_bad++;
        end
        n_cmp++;
`ifdef ARB_PERF_CNT_EN
        if (m1_wait_cnt !== 16'd4) begin $display("FAIL br_wait got %0d want 4", m1_wait_cnt); n_bad++; end
        n_cmp++;
`endif
        cyc();
        m1_req = 0;
        #2;
        if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0 || m0_rlast !== 1'b0) begin
            $display("FAIL br_after got %b%b%b want 100", m1_rvalid, m0_rvalid, m0_rlast); n_bad++;
        end
        n_cmp++;
        cyc();
    endtask

    task automatic test_burst_stall();
        logic [31:0] exp_a;
        int b;
        b = 0;
        m0_burst = 1; m0_we = 1; m0_addr = 32'h40;
        for (int c = 0; c < 6; c++) begin
            m0_req = (c == 2 || c == 3) ? 1'b0 : 1'b1;
            m0_wdata = 32'h1111_0000 + b;
            #2;
            if (!m0_req) begin
                if (mem_en !== 1'b0 || mem_we !== 1'b0 || m0_gnt !== 1'b0) begin
                    $display("FAIL bs%0d_stall got %b%b%b want 000", c, mem_en, mem_we, m0_gnt); n_bad++;
                end
                n_cmp++;
                if (busy !== 1'b1) begin $display("FAIL bs%0d_busy got %h want 1", c, busy); n_bad++; end
                n_cmp++;
            end else begin
                exp_a = 32'h40 + 32'(4 * b);
                if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== exp_a) begin
                    $display("FAIL bs%0d_beat got %b%b %h want 11 %h", c, mem_en, mem_we, mem_addr, exp_a);
                    n_bad++;
                end
                n_cmp++;
                if (mem_wdata !== 32'h1111_0000 + b) begin
                    $display("FAIL bs%0d_wdata got %h want %h", c, mem_wdata, 32'h1111_0000 + b); n_bad++;
                end
                n_cmp++;
                b++;
            end
            cyc();
            m0_burst = 0;
        end
        m0_req = 0; m0_we = 0;
        #2;
        if (busy !== 1'b0 || m0_rvalid !== 1'b0) begin
            $display("FAIL bs_end got %b%b want 00", busy, m0_rvalid); n_bad++;
        end
        n_cmp++;
        cyc();
    endtask

    task automatic test_wrap();
        logic [31:0] exp_a [4];
        exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC;
        exp_a[2] = 32'h0000_0000; exp_a[3] = 32'h0000_0004;
        m0_req = 1; m0_burst = 1; m0_we = 0; m0_addr = 32'hFFFF_FFF8;
        for (int k = 0; k < 4; k++) begin
            #2;
            if (m0_gnt !== 1'b1 || mem_addr !== exp_a[k]) begin
                $display("FAIL wr%0d_addr got %b %h want 1 %h", k, m0_gnt, mem_addr, exp_a[k]); n_bad++;
            end
            n_cmp++;
            cyc();
            m0_burst = 0;
        end
        m0_req = 0;
        #2;
        if (m0_rlast !== 1'b1) begin $display("FAIL wr_rlast got %h want 1", m0_rlast); n_bad++; end
        n_cmp++;
        cyc();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        m0_req = 1; m0_burst = 1; m0_we = 0; m0_addr = 32'h600;
        m1_req = 1; m1_addr = 32'h700;
        cyc();
        m0_burst = 0;
        cyc();
        reset = 1;
        #2;
        if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || mem_en !== 1'b0) begin
            $display("FAIL rm_during got %b%b%b want 000", m0_gnt, m1_gnt, mem_en); n_bad++;
        end
        n_cmp++;
        cyc();
        reset = 0;
        m0_req = 0;
        #2;
        if (busy !== 1'b0 || m0_rvalid !== 1'b0 || m0_rlast !== 1'b0) begin
            $display("FAIL rm_after got %b%b%b want 000", busy, m0_rvalid, m0_rlast); n_bad++;
        end
        n_cmp++;
        if (m1_gnt !== 1'b1 || mem_addr !== 32'h700) begin
            $display("FAIL rm_m1_gnt got %b %h want 1 700", m1_gnt, mem_addr); n_bad++;
        end
        n_cmp++;
`ifdef ARB_PERF_CNT_EN
        if (m1_wait_cnt !== 16'd0) begin $display("FAIL rm_wait got %0d want 0", m1_wait_cnt); n_bad++; end
        n_cmp++;
`endif
        cyc();
        m1_req = 0;
        #2;
        if (m1_rvalid !== 1'b1) begin $display("FAIL rm_m1_rvalid got %h want 1", m1_rvalid); n_bad++; end
        n_cmp++;
        cyc();
    endtask

    initial begin
        reset = 1;
        mem_rdata = 32'h0;
        clear_inputs();
        #1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_burst_read();
        test_burst_stall();
        test_wrap();
        test_reset_mid_burst();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
